// File: rtl/fcfs_rr_arbiter.sv
// Purpose: first-come-first-served arbiter sharing one resource among N requesters. Same-edge
//          arrivals are ordered round-robin after the last grantee, and each tenure is bounded.
// Latency: 1 cycle from first sampled req to grant. Hand-off on release costs no dead cycle.
// Backpressure: none. Requesters hold req high until granted, and the queue cannot overflow.
// Ports:
//   clk_i, rst_ni   rising-edge clock, asynchronous active-low reset
//   req_i           per-requester request level
//   grant_o         registered one-hot grant (all-zero when idle)
//   grant_id_o      index of the holder, 0 when no grant
//   grant_valid_o   OR of grant_o
//   pending_o       number of queued IDs, stale entries included
module fcfs_rr_arbiter #(
  parameter int N        = 4,
  parameter int IDW      = 2,
  parameter int HOLD_MAX = 8
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [N-1:0]   req_i,
  output logic [N-1:0]   grant_o,
  output logic [IDW-1:0] grant_id_o,
  output logic           grant_valid_o,
  output logic [IDW:0]   pending_o
);

  localparam int CW = IDW + 1;
  localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] last_q, last_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [N-1:0]   queued_q, queued_d;
  logic [IDW-1:0] q_q [N];
  logic [IDW-1:0] q_d [N];
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [N-1:0]   new_req;
  logic           holding, release_hit, expire;
  logic           handoff;
  logic [IDW-1:0] head;
  logic [IDW-1:0] idx;

  // The holder is never queued and an already-queued ID never gets a second entry.
  assign new_req     = req_i & ~queued_q & ~grant_q;
  assign holding     = (state_q == GRANT);
  assign release_hit = holding & ~req_i[id_q];
  assign expire      = holding & req_i[id_q] & (HOLD_MAX != 0) &
                       (hold_q == HW'(HOLD_MAX - 1));

  always_comb begin
    q_d      = q_q;
    cnt_d    = cnt_q;
    queued_d = queued_q | new_req;
    state_d  = state_q;
    grant_d  = grant_q;
    id_d     = id_q;
    last_d   = last_q;
    hold_d   = hold_q;
    handoff  = 1'b0;
    head     = '0;
    idx      = '0;

    // Append new arrivals in round-robin order, starting just after the last grantee.
    for (int k = 1; k <= N; k++) begin
      idx = IDW'((int'(last_q) + k) % N);
      if (new_req[idx]) begin
        for (int j = 0; j < N; j++) begin
          if (cnt_d == CW'(j)) q_d[j] = idx;
        end
        cnt_d = cnt_d + CW'(1);
      end
    end

    if (!holding || release_hit) begin
      handoff = 1'b1;
    end else if (expire && cnt_d != '0) begin
      // Tenure expired with someone waiting, so the holder goes to the back of the line.
      for (int j = 0; j < N; j++) begin
        if (cnt_d == CW'(j)) q_d[j] = id_q;
      end
      cnt_d    = cnt_d + CW'(1);
      queued_d = queued_d | grant_q;
      handoff  = 1'b1;
    end

    if (handoff) begin
      grant_d = '0;
      id_d    = '0;
      hold_d  = '0;
      state_d = IDLE;
      if (cnt_d != '0) begin
        head = q_d[0];
        for (int j = 0; j < N - 1; j++) q_d[j] = q_d[j+1];
        q_d[N-1]       = '0;
        cnt_d          = cnt_d - CW'(1);
        queued_d[head] = 1'b0;
        // A head whose req has since dropped is stale. It is discarded, and this cycle stays idle.
        if (req_i[head]) begin
          grant_d[head] = 1'b1;
          id_d          = head;
          last_d        = head;
          state_d       = GRANT;
        end
      end
    end else if (expire) begin
      // Expired but nobody waiting, so the tenure restarts for the same holder.
      hold_d = '0;
      last_d = id_q;
    end else begin
      hold_d = hold_q + HW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      id_q     <= '0;
      last_q   <= IDW'(N - 1);
      hold_q   <= '0;
      queued_q <= '0;
      cnt_q    <= '0;
      for (int j = 0; j < N; j++) q_q[j] <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      id_q     <= id_d;
      last_q   <= last_d;
      hold_q   <= hold_d;
      queued_q <= queued_d;
      cnt_q    <= cnt_d;
      for (int j = 0; j < N; j++) q_q[j] <= q_d[j];
    end
  end

  assign grant_o       = grant_q;
  assign grant_id_o    = id_q;
  assign grant_valid_o = |grant_q;
  assign pending_o     = cnt_q;

endmodule

// File: tb/tb_fcfs_rr_arbiter.sv
// Purpose: directed self-checking bench for fcfs_rr_arbiter (N=4, HOLD_MAX=8).
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: not applicable. Requests are driven as levels.
module tb_fcfs_rr_arbiter;
  localparam int N = 4;
  localparam int IDW = 2;
  localparam int HOLD_MAX = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_id;
  logic           grant_valid;
  logic [IDW:0]   pending;

  int checks = 0;
  int failures = 0;

  fcfs_rr_arbiter #(.N(N), .IDW(IDW), .HOLD_MAX(HOLD_MAX)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_i         (req),
    .grant_o       (grant),
    .grant_id_o    (grant_id),
    .grant_valid_o (grant_valid),
    .pending_o     (pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", grant_id); end
    checks++; if (grant_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", grant_valid); end
    checks++; if (pending !== 3'd0) begin failures++; $display("FAIL reset_pending got=%0d exp=0", pending); end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (grant !== 4'b0001 || grant_valid !== 1'b1 || grant_id !== 2'd0) begin
        failures++; $display("FAIL single_hold c=%0d got=%b/%b/%0d exp=0001/1/0", c, grant, grant_valid, grant_id);
      end
    end
    req = 4'b0000;
    tick();
    checks++; if (grant !== 4'b0000 || grant_valid !== 1'b0) begin failures++; $display("FAIL single_release got=%b/%b exp=0000/0", grant, grant_valid); end
    checks++; if (pending !== 3'd0) begin failures++; $display("FAIL single_pending got=%0d exp=0", pending); end
  endtask

  task automatic test_rr_burst();
    do_reset();
    req = 4'b1111;
    tick();
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL burst_first got=%b exp=0001", grant); end
    checks++; if (pending !== 3'd3) begin failures++; $display("FAIL burst_pending got=%0d exp=3", pending); end
    req = 4'b1110;
    tick();
    checks++; if (grant !== 4'b0010 || pending !== 3'd2) begin failures++; $display("FAIL burst_second got=%b/%0d exp=0010/2", grant, pending); end
    req = 4'b1100;
    tick();
    checks++; if (grant !== 4'b0100 || grant_id !== 2'd2 || pending !== 3'd1) begin failures++; $display("FAIL burst_third got=%b/%0d/%0d exp=0100/2/1", grant, grant_id, pending); end
    req = 4'b1000;
    tick();
    checks++; if (grant !== 4'b1000 || pending !== 3'd0) begin failures++; $display("FAIL burst_fourth got=%b/%0d exp=1000/0", grant, pending); end
    req = 4'b0000;
    tick();
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL burst_idle got=%b exp=0000", grant); end
  endtask

  task automatic test_fcfs_order();
    do_reset();
    req = 4'b0001; tick();
    req = 4'b0101; tick();
    req = 4'b0111; tick();
    req = 4'b1111; tick();
    checks++; if (grant !== 4'b0001 || pending !== 3'd3) begin failures++; $display("FAIL fcfs_queued got=%b/%0d exp=0001/3", grant, pending); end
    req = 4'b1110; tick();
    checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL fcfs_first got=%b exp=0100", grant); end
    req = 4'b1010; tick();
    checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL fcfs_second got=%b exp=0010", grant); end
    req = 4'b1000; tick();
    checks++; if (grant !== 4'b1000 || pending !== 3'd0) begin failures++; $display("FAIL fcfs_third got=%b/%0d exp=1000/0", grant, pending); end
  endtask

  task automatic test_hold_limit();
    logic [N-1:0] exp_g;
    do_reset();
    req = 4'b0011;
    for (int c = 0; c < 24; c++) begin
      tick();
      exp_g = (((c / 8) % 2) == 0) ? 4'b0001 : 4'b0010;
      checks++; if (grant !== exp_g) begin failures++; $display("FAIL hold_toggle c=%0d got=%b exp=%b", c, grant, exp_g); end
    end
    checks++; if (pending !== 3'd1) begin failures++; $display("FAIL hold_pending got=%0d exp=1", pending); end
    do_reset();
    req = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL hold_solo c=%0d got=%b exp=0001", c, grant); end
    end
    checks++; if (pending !== 3'd0) begin failures++; $display("FAIL hold_solo_pending got=%0d exp=0", pending); end
  endtask

  task automatic test_stale();
    do_reset();
    req = 4'b0001; tick();
    req = 4'b0101; tick();
    req = 4'b1101; tick();
    checks++; if (pending !== 3'd2) begin failures++; $display("FAIL stale_queued got=%0d exp=2", pending); end
    req = 4'b1001; tick();
    checks++; if (grant !== 4'b0001 || pending !== 3'd2) begin failures++; $display("FAIL stale_kept got=%b/%0d exp=0001/2", grant, pending); end
    req = 4'b1000; tick();
    checks++; if (grant !== 4'b0000 || pending !== 3'd1) begin failures++; $display("FAIL stale_idle got=%b/%0d exp=0000/1", grant, pending); end
    tick();
    checks++; if (grant !== 4'b1000 || pending !== 3'd0) begin failures++; $display("FAIL stale_next got=%b/%0d exp=1000/0", grant, pending); end
  endtask

  task automatic test_stale_reraise();
    do_reset();
    req = 4'b0001; tick();
    req = 4'b0101; tick();
    req = 4'b1101; tick();
    req = 4'b1001; tick();
    req = 4'b1101; tick();
    checks++; if (pending !== 3'd2) begin failures++; $display("FAIL reraise_nodup got=%0d exp=2", pending); end
    req = 4'b1100; tick();
    checks++; if (grant !== 4'b0100 || pending !== 3'd1) begin failures++; $display("FAIL reraise_pos got=%b/%0d exp=0100/1", grant, pending); end
  endtask

  task automatic test_release_arrival();
    do_reset();
    req = 4'b0001; tick();
    req = 4'b0010; tick();
    checks++; if (grant !== 4'b0010 || grant_id !== 2'd1 || pending !== 3'd0) begin failures++; $display("FAIL relarr got=%b/%0d/%0d exp=0010/1/0", grant, grant_id, pending); end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b0001; tick();
    req = 4'b0111; tick();
    checks++; if (pending !== 3'd2) begin failures++; $display("FAIL areset_pre got=%0d exp=2", pending); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_id !== 2'd0) begin failures++; $display("FAIL areset_grant got=%b/%b/%0d exp=0000/0/0", grant, grant_valid, grant_id); end
    checks++; if (pending !== 3'd0) begin failures++; $display("FAIL areset_pending got=%0d exp=0", pending); end
    req = 4'b0000;
    tick();
    rst_n = 1'b1;
    req = 4'b1010;
    tick();
    checks++; if (grant !== 4'b0010 || pending !== 3'd1) begin failures++; $display("FAIL areset_rr got=%b/%0d exp=0010/1", grant, pending); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_burst();
    test_fcfs_order();
    test_hold_limit();
    test_stale();
    test_stale_reraise();
    test_release_arrival();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fcfs_rr_arbiter.md
Name: fcfs_rr_arbiter

Overview:
- Shares one resource among N requesters. Grants are issued in first-come-first-served order.
- Requests that arrive on the same edge are ordered round-robin.
- Each grant is held while the holder keeps its request high, up to a bounded tenure; expiry forces a hand-off.
- Generalises the 2-requester request-queue arbiter to N requesters, with a pending queue and fairness limit.

Parameters:
N, 4, number of requesters (2..8)
IDW, 2, width of requester ID; must equal clog2(N)
HOLD_MAX, 8, max consecutive grant cycles per tenure; 0 = unlimited

Ports:
clock  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-low; arbiter held in reset while 0
req  in  N  per-requester request level; held high while resource needed
grant  out  N  one-hot grant, registered; all-zero when no holder
grant_id  out  IDW  index of current holder; 0 when grant_valid=0
grant_valid  out  1  OR of grant
pending  out  IDW+1  number of IDs currently in queue (0..N-1)

Behaviour:
Reset:
- reset=0 forces grant=0, grant_id=0, grant_valid=0, pending=0.
- Reset also empties the queue, clears all queued flags, sets last_id=N-1 and hold_cnt=0, and puts the FSM in IDLE.
- Asserting reset mid-tenure drops the grant immediately; there is no hand-off.

Enqueue:
- At each edge, requester i is "new" if req[i]=1, it is not the holder and its queued flag is clear.
- All new requesters are pushed at the tail that edge, in order last_id+1, last_id+2, ... (mod N); their queued flags are set.
- Queue depth is N. It cannot overflow because each ID has at most one entry and the holder is never queued.

FSM:
IDLE (grant=0):
- If the queue is empty and some requesters are new, the first of them in round-robin order is granted directly. Grant is visible the cycle after the edge that first sampled req high (1-cycle latency). The rest are enqueued.
- Otherwise, if the queue is non-empty, pop the head and clear its queued flag:
  - req[head]=1: grant head, go to GRANT.
  - req[head]=0: stale entry, discarded. Stay IDLE for that cycle, then examine the next entry on the next edge.
GRANT (one-hot grant to holder h):
- req[h]=0 at an edge is a release. The same edge pops the head (stale rule applies) and grants it with no dead cycle. If the queue is empty, go to IDLE with grant=0.
- If req[h]=1 and HOLD_MAX≠0 and hold_cnt=HOLD_MAX-1:
  - With a non-empty queue, h is pushed at the tail and the head is granted that edge.
  - With an empty queue, h keeps the grant and hold_cnt restarts at 0.
- hold_cnt increments each GRANT cycle and clears on every new grant.
- last_id updates to the granted ID on every grant.

Boundary rules:
- Release and a new arrival on the same edge: the arrival is enqueued first, then the pop occurs, so a lone arrival is granted that edge.
- Stale-then-reasserted ID: if the queued flag is still set when the requester re-raises req, no duplicate entry is made and its original position is kept.
- A requester dropping and re-raising req between edges is invisible (level-sampled).
- pending counts stale entries until they are popped.

Test Plan:
- Reset, then req=4'b0001 for 3 cycles, then 0 → grant=0001 one cycle after first sample; grant_valid=1 for 3 cycles; then grant=0000, pending=0.
- After reset, req=4'b1111 on one edge → grant=0001, pending=3, queue order 1,2,3. req[0] dropped → grant=0010 the next edge, no dead cycle.
- req[2] at edge t, req[1] at t+1, req[3] at t+2, while 0 holds the grant → after 0 releases, grants occur in order 2,1,3.
- HOLD_MAX=8, req[0] and req[1] held high continuously → grant toggles 0001/0010 every 8 cycles. With only req[0] high, grant stays 0001 indefinitely.
- Queue ID 2 behind holder 0, drop req[2] before 0 releases → on release, one IDLE cycle with grant=0000, pending decrements, and the next entry is granted the following edge.
- Assert reset=0 mid-tenure with pending=2 → grant=0000, pending=0 immediately, without waiting for a clock edge. After release, req=4'b1010 → grant=0010 (round-robin restarts from ID 0).
